// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern engine: pattern encoding,
// colour constants and a constant log2 helper.
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_BOX   = 2'd3
  } pat_e;

  localparam logic [23:0] RGB_BLACK = 24'h000000;
  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;

  // Smallest r with 2**r >= v; used on power-of-two widths.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position state. Advances one step per enabled frame strobe,
// clamping at the edges of the active area and reversing direction there.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int WIDTH    = 1024,
  parameter int HEIGHT   = 768,
  parameter int BOX_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_step,
  input  logic [3:0]  i_speed,
  output logic [11:0] o_box_x,
  output logic [11:0] o_box_y
);

  localparam logic [11:0] XMAX = 12'(WIDTH - BOX_SIZE);
  localparam logic [11:0] YMAX = 12'(HEIGHT - BOX_SIZE);

  logic [11:0] r_box_x, r_box_y;
  logic        r_dir_x, r_dir_y;   // 0 = moving +, 1 = moving -
  logic [11:0] w_nx, w_ny;
  logic        w_ndx, w_ndy;
  logic [11:0] w_spd;

  // One axis step: returns {new_dir, new_pos}. 12-bit math cannot wrap
  // because positions stay below 2048 and speed is at most 15.
  function automatic logic [12:0] step_axis(input logic [11:0] pos,
                                            input logic        dir,
                                            input logic [11:0] spd,
                                            input logic [11:0] lim);
    logic [12:0] res;
    if (!dir) begin
      if (pos + spd >= lim) res = {1'b1, lim};
      else                  res = {1'b0, pos + spd};
    end else begin
      if (pos <= spd)       res = {1'b0, 12'd0};
      else                  res = {1'b1, pos - spd};
    end
    return res;
  endfunction

  assign w_spd = {8'd0, i_speed};

  // Next position/direction for both axes.
  always_comb begin
    {w_ndx, w_nx} = step_axis(r_box_x, r_dir_x, w_spd, XMAX);
    {w_ndy, w_ny} = step_axis(r_box_y, r_dir_y, w_spd, YMAX);
  end

  // Box state register; zero speed leaves position and direction untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_box_x <= '0;
      r_box_y <= '0;
      r_dir_x <= 1'b0;
      r_dir_y <= 1'b0;
    end else if (i_step && (i_speed != 4'd0)) begin
      r_box_x <= w_nx;
      r_box_y <= w_ny;
      r_dir_x <= w_ndx;
      r_dir_y <= w_ndy;
    end
  end

  assign o_box_x = r_box_x;
  assign o_box_y = r_box_y;

endmodule

// File: rtl/vga_pattern_engine.sv
// Test-pattern pixel source for the VGA driver: colour bars, checkerboard,
// grey ramp and a bouncing box. Pattern select and box motion change only at
// the frame-update point so a frame is never torn.
module vga_pattern_engine
  import vga_pkg::*;
#(
  parameter int          WIDTH      = 1024,
  parameter int          HEIGHT     = 768,
  parameter int          CHECK_LOG2 = 5,
  parameter int          BOX_SIZE   = 64,
  parameter logic [23:0] BOX_RGB    = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB     = 24'h000080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] ctr_h,
  input  logic [9:0]  ctr_v,
  input  logic [1:0]  pattern_sel,
  input  logic [3:0]  speed,
  input  logic        freeze,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_tick
);

  localparam int          LOG2W    = clog2_f(WIDTH);
  localparam int          BAR_SH   = LOG2W - 3;
  localparam int          RAMP_SH  = LOG2W - 8;
  localparam logic [10:0] L_WIDTH  = 11'(WIDTH);
  localparam logic [9:0]  L_HEIGHT = 10'(HEIGHT);
  localparam logic [11:0] L_BOX    = 12'(BOX_SIZE);

  logic [9:0]  r_prev_v;
  logic        r_frame_tick;
  pat_e        r_pat;
  logic [23:0] r_rgb_p1;

  logic        w_frame;
  logic        w_active;
  logic [2:0]  w_bar_idx;
  logic [7:0]  w_grey;
  logic        w_check;
  logic [11:0] w_h12, w_v12;
  logic        w_in_box;
  logic [11:0] w_box_x, w_box_y;
  logic [23:0] w_rgb;

  // Frame strobe: first cycle of line HEIGHT, guarded by prev_v so it fires once.
  assign w_frame = (ctr_v == L_HEIGHT) && (ctr_h == 11'd0) && (r_prev_v != L_HEIGHT);

  vga_box_mover #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_step  (w_frame && !freeze),
    .i_speed (speed),
    .o_box_x (w_box_x),
    .o_box_y (w_box_y)
  );

  assign w_active  = (ctr_h < L_WIDTH) && (ctr_v < L_HEIGHT);
  assign w_bar_idx = 3'(ctr_h >> BAR_SH);
  assign w_grey    = 8'(ctr_h >> RAMP_SH);
  assign w_check   = ctr_h[CHECK_LOG2] ^ ctr_v[CHECK_LOG2];
  assign w_h12     = {1'b0, ctr_h};
  assign w_v12     = {2'b0, ctr_v};
  assign w_in_box  = (w_h12 >= w_box_x) && (w_h12 < w_box_x + L_BOX) &&
                     (w_v12 >= w_box_y) && (w_v12 < w_box_y + L_BOX);

  // Pattern mux for the current coordinate; blanking forces black.
  always_comb begin
    w_rgb = RGB_BLACK;
    if (w_active) begin
      case (r_pat)
        PAT_BARS:  w_rgb = {{8{w_bar_idx[0]}}, {8{w_bar_idx[1]}}, {8{w_bar_idx[2]}}};
        PAT_CHECK: w_rgb = w_check ? RGB_WHITE : RGB_BLACK;
        PAT_RAMP:  w_rgb = {w_grey, w_grey, w_grey};
        PAT_BOX:   w_rgb = w_in_box ? BOX_RGB : BG_RGB;
        default:   w_rgb = RGB_BLACK;
      endcase
    end
  end

  // Frame-boundary control: prev line tracker, tick pulse and pattern latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_v     <= '0;
      r_frame_tick <= 1'b0;
      r_pat        <= PAT_BARS;
    end else begin
      r_prev_v     <= ctr_v;
      r_frame_tick <= w_frame;
      if (w_frame) r_pat <= pat_e'(pattern_sel);
    end
  end

  // Output pixel register: one cycle behind the sampled coordinate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rgb_p1 <= '0;
    else        r_rgb_p1 <= w_rgb;
  end

  assign vga_r      = r_rgb_p1[23:16];
  assign vga_g      = r_rgb_p1[15:8];
  assign vga_b      = r_rgb_p1[7:0];
  assign frame_tick = r_frame_tick;

endmodule
